// File: rtl/sram_read_sequencer.sv
// Read-side timing controller for the SRAM macro.
// Sequence per read: PRECH -> GUARD (break-before-make) -> DEV (wordline on)
// -> SENSE (sense amps on), then the sensed word is returned on a valid/ready
// response. All array controls are registered from the next state so the
// decoder, wordline drivers and sense amps never see combinational glitches.
module sram_read_sequencer #(
    parameter int ROW_BITS  = 6,
    parameter int COL_BITS  = 3,
    parameter int DATA_W    = 8,
    parameter int PRECH_CYC = 2,
    parameter int DEV_CYC   = 2,
    parameter int SENSE_CYC = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ROW_BITS-1:0]    req_row,
    input  logic [COL_BITS-1:0]    req_col,
    output logic [ROW_BITS-1:0]    row_addr,
    output logic                   wl_en,
    output logic                   prech_en,
    output logic [(1<<COL_BITS)-1:0] col_sel,
    output logic                   sa_en,
    input  logic [DATA_W-1:0]      sa_out,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   busy
);

    localparam int NCOL = 1 << COL_BITS;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRECH = 3'd1,
        GUARD = 3'd2,
        DEV   = 3'd3,
        SENSE = 3'd4
    } state_t;

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic [ROW_BITS-1:0] row_reg, row_next;
    logic [COL_BITS-1:0] col_reg, col_next;
    logic                rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0]   rd_data_reg, rd_data_next;
    logic                prech_reg, prech_next;
    logic                wl_reg, wl_next;
    logic                sa_reg, sa_next;
    logic [NCOL-1:0]     col_sel_reg, col_sel_next;
    logic [NCOL-1:0]     col_onehot;
    logic                accept;

    // One-hot decode of the latched column, one comparator per mux leg.
    genvar gi;
    generate
        for (gi = 0; gi < NCOL; gi++) begin : g_col_dec
            assign col_onehot[gi] = (col_reg == COL_BITS'(gi));
        end
    endgenerate

    // A new request may enter only from IDLE, and only if the previous
    // response is absent or retiring in this same cycle.
    assign req_ready = (state_reg == IDLE) && (!rsp_valid_reg || rsp_ready);
    assign accept    = req_valid && req_ready;

    // Next-state, counter, latch and response logic.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        row_next       = row_reg;
        col_next       = col_reg;
        rsp_valid_next = rsp_valid_reg;
        rd_data_next   = rd_data_reg;

        if (rsp_valid_reg && rsp_ready) begin
            rsp_valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    row_next   = req_row;
                    col_next   = req_col;
                    cnt_next   = 4'(PRECH_CYC);
                    state_next = PRECH;
                end
            end
            PRECH: begin
                if (cnt_reg == 4'd1) begin
                    state_next = GUARD;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            GUARD: begin
                cnt_next   = 4'(DEV_CYC);
                state_next = DEV;
            end
            DEV: begin
                if (cnt_reg == 4'd1) begin
                    cnt_next   = 4'(SENSE_CYC);
                    state_next = SENSE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            SENSE: begin
                if (cnt_reg == 4'd1) begin
                    rd_data_next   = sa_out;
                    rsp_valid_next = 1'b1;
                    cnt_next       = 4'd0;
                    state_next     = IDLE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Array controls decoded from the next state so they register in step
    // with the state itself.
    always_comb begin
        prech_next   = (state_next == IDLE) || (state_next == PRECH);
        wl_next      = (state_next == DEV);
        sa_next      = (state_next == SENSE);
        col_sel_next = '0;
        if ((state_next == GUARD) || (state_next == DEV) || (state_next == SENSE)) begin
            col_sel_next = col_onehot;
        end
    end

    // State and output registers; reset lands in precharged idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            row_reg       <= '0;
            col_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rd_data_reg   <= '0;
            prech_reg     <= 1'b1;
            wl_reg        <= 1'b0;
            sa_reg        <= 1'b0;
            col_sel_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            row_reg       <= row_next;
            col_reg       <= col_next;
            rsp_valid_reg <= rsp_valid_next;
            rd_data_reg   <= rd_data_next;
            prech_reg     <= prech_next;
            wl_reg        <= wl_next;
            sa_reg        <= sa_next;
            col_sel_reg   <= col_sel_next;
        end
    end

    assign row_addr  = row_reg;
    assign wl_en     = wl_reg;
    assign prech_en  = prech_reg;
    assign sa_en     = sa_reg;
    assign col_sel   = col_sel_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rd_data   = rd_data_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_sram_read_sequencer.sv
// Directed bench for sram_read_sequencer: default instance checked cycle by
// cycle, plus all-1 and all-15 timing instances for latency corners.
module tb_sram_read_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [5:0] req_row;
    logic [2:0] req_col;
    logic [7:0] sa_out;
    logic       rsp_ready;

    // default-timing instance
    logic       req_ready, wl_en, prech_en, sa_en, rsp_valid, busy;
    logic [5:0] row_addr;
    logic [7:0] col_sel, rd_data;
    // all-1 timing instance
    logic       req_ready_a, wl_en_a, prech_en_a, sa_en_a, rsp_valid_a, busy_a;
    logic [5:0] row_addr_a;
    logic [7:0] col_sel_a, rd_data_a;
    // all-15 timing instance
    logic       req_ready_b, wl_en_b, prech_en_b, sa_en_b, rsp_valid_b, busy_b;
    logic [5:0] row_addr_b;
    logic [7:0] col_sel_b, rd_data_b;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sram_read_sequencer dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_row(req_row), .req_col(req_col), .row_addr(row_addr), .wl_en(wl_en),
        .prech_en(prech_en), .col_sel(col_sel), .sa_en(sa_en), .sa_out(sa_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rd_data(rd_data), .busy(busy)
    );

    sram_read_sequencer #(.PRECH_CYC(1), .DEV_CYC(1), .SENSE_CYC(1)) u_min (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_a),
        .req_row(req_row), .req_col(req_col), .row_addr(row_addr_a), .wl_en(wl_en_a),
        .prech_en(prech_en_a), .col_sel(col_sel_a), .sa_en(sa_en_a), .sa_out(sa_out),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rd_data(rd_data_a), .busy(busy_a)
    );

    sram_read_sequencer #(.PRECH_CYC(15), .DEV_CYC(15), .SENSE_CYC(15)) u_max (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_b),
        .req_row(req_row), .req_col(req_col), .row_addr(row_addr_b), .wl_en(wl_en_b),
        .prech_en(prech_en_b), .col_sel(col_sel_b), .sa_en(sa_en_b), .sa_out(sa_out),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rd_data(rd_data_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Array-control overlap and one-hot rules on every instance, every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("inv_wl_prech", 32'(wl_en & prech_en), 0);
            chk("inv_wl_sa", 32'(wl_en & sa_en), 0);
            chk("inv_onehot", 32'($countones(col_sel) <= 1), 1);
            chk("inv_wl_prech_min", 32'(wl_en_a & prech_en_a), 0);
            chk("inv_wl_sa_min", 32'(wl_en_a & sa_en_a), 0);
            chk("inv_onehot_min", 32'($countones(col_sel_a) <= 1), 1);
            chk("inv_wl_prech_max", 32'(wl_en_b & prech_en_b), 0);
            chk("inv_wl_sa_max", 32'(wl_en_b & sa_en_b), 0);
            chk("inv_onehot_max", 32'($countones(col_sel_b) <= 1), 1);
        end
    end

    // Check one in-flight cycle of the default instance.
    task automatic exp_phase(input string tag, input logic p, input logic w, input logic s,
                             input logic [7:0] cs, input logic [5:0] row);
        chk({tag, ".prech_en"}, 32'(prech_en), 32'(p));
        chk({tag, ".wl_en"}, 32'(wl_en), 32'(w));
        chk({tag, ".sa_en"}, 32'(sa_en), 32'(s));
        chk({tag, ".col_sel"}, 32'(col_sel), 32'(cs));
        chk({tag, ".row_addr"}, 32'(row_addr), 32'(row));
        chk({tag, ".busy"}, 32'(busy), 1);
        chk({tag, ".req_ready"}, 32'(req_ready), 0);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 0);
    endtask

    task automatic noise;
        req_valid = 1'($urandom);
        req_row   = 6'($urandom);
        req_col   = 3'($urandom);
    endtask

    // Present a request, confirm it is accepted on the next edge.
    task automatic issue(input logic [5:0] row, input logic [2:0] col);
        req_row   = row;
        req_col   = col;
        req_valid = 1'b1;
        #1;
        chk("issue.req_ready", 32'(req_ready), 1);
        tick;
        req_valid = 1'b0;
        chk("issue.busy", 32'(busy), 1);
        chk("issue.rsp_valid", 32'(rsp_valid), 0);
    endtask

    // Walk PRECH(2) / GUARD(1) / DEV(2) / SENSE(1); sa_out carries the real
    // word only in the SENSE cycle so a mistimed capture reads ~data.
    task automatic run_phases(input logic [5:0] row, input logic [2:0] col,
                              input logic [7:0] data, input bit with_noise);
        logic [7:0] oh;
        oh = 8'b1 << col;
        sa_out = ~data;
        for (int i = 0; i < 2; i++) begin
            exp_phase("prech", 1'b1, 1'b0, 1'b0, 8'h00, row);
            if (with_noise) noise();
            tick;
        end
        exp_phase("guard", 1'b0, 1'b0, 1'b0, oh, row);
        if (with_noise) noise();
        tick;
        for (int i = 0; i < 2; i++) begin
            exp_phase("dev", 1'b0, 1'b1, 1'b0, oh, row);
            if (with_noise) noise();
            tick;
        end
        sa_out = data;
        exp_phase("sense", 1'b0, 1'b0, 1'b1, oh, row);
        req_valid = 1'b0;
        tick;
        sa_out = ~data;
        chk("rsp.rsp_valid", 32'(rsp_valid), 1);
        chk("rsp.rd_data", 32'(rd_data), 32'(data));
        chk("rsp.prech_en", 32'(prech_en), 1);
        chk("rsp.col_sel", 32'(col_sel), 0);
        chk("rsp.busy", 32'(busy), 0);
    endtask

    initial begin
        int lat_main, lat_min, lat_max, last_acc, acc;
        logic [5:0] r;
        logic [2:0] c;
        logic [7:0] d;

        rst_n = 1'b0; req_valid = 1'b0; req_row = '0; req_col = '0;
        sa_out = '0; rsp_ready = 1'b1;

        // --- reset values ---
        repeat (3) @(posedge clk);
        #1;
        chk("rst.prech_en", 32'(prech_en), 1);
        chk("rst.wl_en", 32'(wl_en), 0);
        chk("rst.sa_en", 32'(sa_en), 0);
        chk("rst.col_sel", 32'(col_sel), 0);
        chk("rst.row_addr", 32'(row_addr), 0);
        chk("rst.rd_data", 32'(rd_data), 0);
        chk("rst.rsp_valid", 32'(rsp_valid), 0);
        chk("rst.busy", 32'(busy), 0);
        rst_n = 1'b1;
        tick;
        chk("rst.req_ready", 32'(req_ready), 1);

        // --- latency corners: all three instances accept the same pulse ---
        req_row = 6'd1; req_col = 3'd0; req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        lat_main = 0; lat_min = 0; lat_max = 0;
        for (int n = 1; n <= 60; n++) begin
            tick;
            if (rsp_valid   && lat_main == 0) lat_main = n;
            if (rsp_valid_a && lat_min  == 0) lat_min  = n;
            if (rsp_valid_b && lat_max  == 0) lat_max  = n;
        end
        chk("lat.default", lat_main, 6);
        chk("lat.all1", lat_min, 4);
        chk("lat.all15", lat_max, 46);
        chk("lat.idle_after", 32'(busy | busy_a | busy_b), 0);

        // --- single read ---
        issue(6'd37, 3'd5);
        chk("single.row_addr", 32'(row_addr), 37);
        run_phases(6'd37, 3'd5, 8'hA5, 1'b0);
        tick;
        chk("single.retired", 32'(rsp_valid), 0);
        chk("single.rd_kept", 32'(rd_data), 32'hA5);
        repeat (3) begin
            tick;
            chk("single.no_extra", 32'(rsp_valid), 0);
        end

        // --- backpressure with ignored requests during the read ---
        rsp_ready = 1'b0;
        issue(6'd12, 3'd2);
        run_phases(6'd12, 3'd2, 8'h3C, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("bp.rsp_valid", 32'(rsp_valid), 1);
            chk("bp.rd_data", 32'(rd_data), 32'h3C);
            chk("bp.req_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        issue(6'd50, 3'd7);
        chk("bp.new_row", 32'(row_addr), 50);
        chk("bp.rd_held", 32'(rd_data), 32'h3C);
        run_phases(6'd50, 3'd7, 8'h81, 1'b0);
        tick;
        chk("bp.retired", 32'(rsp_valid), 0);

        // --- ignored requests, then confirm no stray response ---
        issue(6'd9, 3'd1);
        run_phases(6'd9, 3'd1, 8'h5E, 1'b1);
        repeat (4) begin
            tick;
            chk("ign.no_extra", 32'(rsp_valid), 0);
            chk("ign.row_addr", 32'(row_addr), 9);
        end

        // --- back-to-back: accept-to-accept is latency plus the IDLE cycle ---
        last_acc = -1;
        for (int k = 0; k < 16; k++) begin
            r = 6'($urandom_range(63));
            c = 3'($urandom_range(7));
            d = 8'($urandom_range(255));
            issue(r, c);
            acc = cyc;
            if (last_acc >= 0) chk("b2b.interval", acc - last_acc, 7);
            last_acc = acc;
            run_phases(r, c, d, k[0]);
        end
        tick;
        chk("b2b.retired", 32'(rsp_valid), 0);

        // --- asynchronous abort in DEV ---
        issue(6'd21, 3'd3);
        repeat (3) tick;
        chk("abort.wl_before", 32'(wl_en), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort.wl_en", 32'(wl_en), 0);
        chk("abort.prech_en", 32'(prech_en), 1);
        chk("abort.rsp_valid", 32'(rsp_valid), 0);
        chk("abort.col_sel", 32'(col_sel), 0);
        chk("abort.busy", 32'(busy), 0);
        repeat (2) tick;
        rst_n = 1'b1;
        tick;
        chk("abort.req_ready", 32'(req_ready), 1);
        repeat (8) begin
            tick;
            chk("abort.no_stale", 32'(rsp_valid), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
